// File: rtl/packet_switch_param.sv
// packet_switch_param: NCH x NCH word switch. Per-input FIFOs feed a
// round-robin arbiter that moves one word per cycle into the output FIFO
// named by the word's destination field. Output FIFOs raise hysteresis
// backpressure between programmable alto/bajo thresholds.

// Single-clock FIFO lane; head is visible combinationally on dout.
module psw_fifo #(
  parameter int DW    = 10,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          rd,
  output logic [DW-1:0] dout,
  output logic [AW:0]   count
);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][DW-1:0] mem;
  logic [AW-1:0]            wp, rp;
  logic                     rd_ok, wr_ok;

  // a full FIFO still takes a write when its head leaves in the same cycle
  assign rd_ok = rd & (count != '0);
  assign wr_ok = wr & ((count != FULL_C) | rd_ok);
  assign dout  = mem[rp];

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wp <= wp + AW'(1);
      if (rd_ok) rp <= rp + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // storage; stale words are unreachable once pointers reset
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wp] <= din;
  end
endmodule

module packet_switch_param #(
  parameter int NCH   = 4,
  parameter int DW    = 10,
  parameter int DEPTH = 8,
  parameter int CNTW  = 5,
  localparam int CW   = $clog2(NCH),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [AW:0]       alto,
  input  logic [AW:0]       bajo,
  input  logic [NCH*DW-1:0] data_in,
  input  logic [NCH-1:0]    push,
  input  logic [NCH-1:0]    pop,
  output logic [NCH*DW-1:0] data_out,
  output logic [NCH-1:0]    in_full,
  output logic [NCH-1:0]    out_empty,
  input  logic [CW-1:0]     idx,
  input  logic              req,
  output logic [CNTW-1:0]   cnt_out,
  output logic              cnt_valid,
  output logic              idle,
  output logic              error,
  output logic [2:0]        state
);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } st_t;

  st_t st, nx;

  logic [NCH-1:0][DW-1:0]   din_a, ihead, ohead, dout_q;
  logic [NCH-1:0][AW:0]     icnt, ocnt;
  logic [NCH-1:0]           iempty, ifull, oempty;
  logic [NCH-1:0]           ipush, ipop, opush, opop;
  logic [NCH-1:0]           bp, bp_q;
  logic [NCH-1:0][CNTW-1:0] cnt;
  logic [AW:0]              alto_q, bajo_q;
  logic [CW-1:0]            rr, gnt, cand;
  logic [DW-1:0]            xfer_word;
  logic [CW-1:0]            xfer_dst;
  logic                     xfer, ovf;

  assign din_a     = data_in;
  assign data_out  = dout_q;
  assign in_full   = ifull;
  assign out_empty = oempty;
  assign state     = st;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    psw_fifo #(.DW(DW), .DEPTH(DEPTH)) u_in (
      .clk(clk), .rst_n(reset), .wr(ipush[i]), .din(din_a[i]),
      .rd(ipop[i]), .dout(ihead[i]), .count(icnt[i])
    );
    psw_fifo #(.DW(DW), .DEPTH(DEPTH)) u_out (
      .clk(clk), .rst_n(reset), .wr(opush[i]), .din(xfer_word),
      .rd(opop[i]), .dout(ohead[i]), .count(ocnt[i])
    );
    assign iempty[i] = (icnt[i] == '0);
    assign ifull[i]  = (icnt[i] == DEPTH_C);
    assign oempty[i] = (ocnt[i] == '0);
  end

  // pushes stop in ERROR; a push into a full, undrained input is an overflow
  assign ipush = (st == S_ERROR) ? '0 : push;
  assign ovf   = (st != S_ERROR) && |(push & ifull & ~ipop);
  assign opop  = pop & ~oempty;

  // backpressure reacts to the live count so a crossing blocks the very next transfer
  always_comb begin
    bp = bp_q;
    for (int j = 0; j < NCH; j++) begin
      if (ocnt[j] >= alto_q)      bp[j] = 1'b1;
      else if (ocnt[j] <= bajo_q) bp[j] = 1'b0;
    end
  end

  // round-robin grant from rr upward, one transfer per cycle
  always_comb begin
    xfer  = 1'b0;
    gnt   = rr;
    cand  = rr;
    ipop  = '0;
    opush = '0;
    if (st == S_ACTIVE) begin
      for (int k = 0; k < NCH; k++) begin
        cand = rr + CW'(k);
        if (!xfer && !iempty[cand] && !bp[ihead[cand][DW-1 -: CW]]) begin
          xfer = 1'b1;
          gnt  = cand;
        end
      end
    end
    xfer_word = ihead[gnt];
    xfer_dst  = xfer_word[DW-1 -: CW];
    if (xfer) begin
      ipop[gnt]      = 1'b1;
      opush[xfer_dst] = 1'b1;
    end
  end

  // control FSM next state; overflow overrides everything
  always_comb begin
    nx = st;
    case (st)
      S_RESET:  nx = S_INIT;
      S_INIT:   if (!init) nx = (bajo >= alto || alto > DEPTH_C) ? S_ERROR : S_IDLE;
      S_IDLE:   if (init) nx = S_INIT;
                else if (!(&iempty) || |ipush) nx = S_ACTIVE;
      S_ACTIVE: if (init) nx = S_INIT;
                else if (&iempty && !xfer) nx = S_IDLE;
      S_ERROR:  nx = S_ERROR;
      default:  nx = S_ERROR;
    endcase
    if (ovf) nx = S_ERROR;
  end

  // state, registered flags, thresholds, arbiter pointer, outputs and counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= S_RESET;
      idle      <= 1'b0;
      error     <= 1'b0;
      alto_q    <= (AW+1)'(DEPTH - 1);
      bajo_q    <= (AW+1)'(1);
      rr        <= '0;
      bp_q      <= '0;
      dout_q    <= '0;
      cnt       <= '0;
      cnt_out   <= '0;
      cnt_valid <= 1'b0;
    end else begin
      st    <= nx;
      idle  <= (nx == S_IDLE);
      error <= (nx == S_ERROR);
      if (st == S_INIT) begin
        alto_q <= alto;
        bajo_q <= bajo;
      end
      if (xfer) rr <= gnt + CW'(1);
      bp_q <= bp;
      for (int j = 0; j < NCH; j++) begin
        if (opop[j]) begin
          dout_q[j] <= ohead[j];
          cnt[j]    <= cnt[j] + CNTW'(1);
        end
      end
      cnt_valid <= (st == S_IDLE) && req;
      if ((st == S_IDLE) && req) cnt_out <= cnt[idx];
    end
  end
endmodule

// File: tb/tb_packet_switch_param.sv
// Bench for packet_switch_param: directed flow/threshold/error/counter
// scenarios plus a randomized traffic phase scored against per-(src,dst)
// expected queues and per-output pop counts.
module tb_packet_switch_param;
  localparam int NCH = 4, DW = 10, DEPTH = 8, CNTW = 5, CW = 2, AW = 3;

  logic              clk = 1'b0, reset = 1'b0, init = 1'b0, req = 1'b0;
  logic [AW:0]       alto = '0, bajo = '0;
  logic [NCH*DW-1:0] data_in = '0;
  logic [NCH-1:0]    push = '0, pop = '0;
  logic [CW-1:0]     idx = '0;
  logic [NCH*DW-1:0] data_out;
  logic [NCH-1:0]    in_full, out_empty;
  logic [CNTW-1:0]   cnt_out;
  logic              cnt_valid, idle, error;
  logic [2:0]        state;

  packet_switch_param #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .init(init), .alto(alto), .bajo(bajo),
    .data_in(data_in), .push(push), .pop(pop), .data_out(data_out),
    .in_full(in_full), .out_empty(out_empty), .idx(idx), .req(req),
    .cnt_out(cnt_out), .cnt_valid(cnt_valid), .idle(idle), .error(error),
    .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // scoreboard: expected words per (src*NCH+dst), and expected pop counts
  logic [DW-1:0] exp_q [NCH*NCH][$];
  int            popm [NCH];
  int            seqc [NCH*NCH];
  logic          mon_en = 1'b0;
  logic [NCH-1:0] pend = '0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkw(input int d, input int s, input int q);
    return DW'((d << (DW-CW)) | (s << (DW-2*CW)) | (q & 63));
  endfunction

  function automatic logic [DW-1:0] dout(input int j);
    return data_out[j*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] w);
    data_in[i*DW +: DW] = w;
  endtask

  task automatic do_reset();
    reset = 1'b0; push = '0; pop = '0; init = 1'b0; req = 1'b0;
    #1;
    ticks(2);
    reset = 1'b1;
  endtask

  task automatic init_cfg(input int a, input int b);
    alto = (AW+1)'(a); bajo = (AW+1)'(b); init = 1'b1;
    ticks(2);
    init = 1'b0;
    tick();
  endtask

  task automatic send_and_pop(input int s, input int d, input int q);
    logic [DW-1:0] w;
    int n;
    w = mkw(d, s, q);
    set_word(s, w); push[s] = 1'b1;
    tick();
    push[s] = 1'b0;
    n = 0;
    while (out_empty[d] && n < 20) begin tick(); n++; end
    chk("sp_arrive", out_empty[d], 0);
    pop[d] = 1'b1;
    tick();
    pop[d] = 1'b0;
    chk("sp_data", dout(d), w);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!idle && n < 30) begin tick(); n++; end
    chk("to_idle", idle, 1);
  endtask

  // monitor: a pop seen before an edge is scored on data_out after it
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      for (int j = 0; j < NCH; j++) begin
        if (pend[j]) begin
          logic [DW-1:0] w;
          int s;
          w = dout(j);
          s = int'(w[DW-1-CW -: CW]);
          popm[j]++;
          if (exp_q[s*NCH+j].size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_unexpected: out %0d got %0h expected none", j, w);
          end else begin
            chk($sformatf("sb_out%0d", j), w, exp_q[s*NCH+j].pop_front());
          end
        end
      end
      pend = pop & ~out_empty;
    end else begin
      pend = '0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] ew [8];
    int n, rem, a, b;

    // ---- reset values and bring-up sequence 0 -> 1 -> 2
    #3;
    chk("rst_state", state, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_oempty", out_empty, 4'hF);
    chk("rst_infull", in_full, 0);
    chk("rst_idle", idle, 0);
    chk("rst_error", error, 0);
    chk("rst_cntv", cnt_valid, 0);
    chk("rst_cnt", cnt_out, 0);
    ticks(2);
    reset = 1'b1;
    init = 1'b1; alto = 4'd6; bajo = 4'd2;
    tick();
    chk("bring_init", state, 1);
    tick();
    init = 1'b0;
    tick();
    chk("bring_idle_st", state, 2);
    chk("bring_idle", idle, 1);
    chk("bring_oempty", out_empty, 4'hF);

    // ---- single word 0x0C5 on input 2 to output 0
    set_word(2, 10'h0C5); push = 4'b0100;
    tick();
    push = '0;
    chk("w1_st_active", state, 3);
    chk("w1_not_yet", out_empty[0], 1);
    tick();
    chk("w1_arrived", out_empty[0], 0);
    pop[0] = 1'b1;
    tick();
    pop[0] = 1'b0;
    chk("w1_dout", dout(0), 10'h0C5);
    chk("w1_back_idle", state, 2);
    pop[0] = 1'b1;
    tick();
    pop[0] = 1'b0;
    chk("w1_pop_empty_hold", dout(0), 10'h0C5);
    chk("w1_pop_empty_noerr", error, 0);
    idx = 0; req = 1'b1;
    tick();
    req = 1'b0;
    chk("w1_cntv", cnt_valid, 1);
    chk("w1_cnt", cnt_out, 1);
    tick();
    chk("w1_cntv_drop", cnt_valid, 0);

    // ---- round robin and hysteresis on output 1
    do_reset();
    alto = 4'd6; bajo = 4'd2; init = 1'b1;
    tick();
    for (int q = 0; q < 2; q++) begin
      for (int i = 0; i < NCH; i++) set_word(i, mkw(1, i, q));
      push = '1;
      tick();
    end
    push = '0;
    chk("rr_in_init", state, 1);
    init = 1'b0;
    tick();
    ticks(12);
    chk("rr_stalled", state, 3);
    for (int k = 0; k < 8; k++) ew[k] = mkw(1, k % 4, k / 4);
    pop[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rr_ord%0d", k), dout(1), ew[k]);
    end
    pop[1] = 1'b0;
    ticks(6);
    chk("bp_holds_above_bajo", state, 3);
    pop[1] = 1'b1;
    tick();
    pop[1] = 1'b0;
    chk("rr_ord3", dout(1), ew[3]);
    ticks(6);
    chk("bp_released", state, 2);
    pop[1] = 1'b1;
    for (int k = 4; k < 8; k++) begin
      tick();
      chk($sformatf("rr_ord%0d", k), dout(1), ew[k]);
    end
    pop[1] = 1'b0;
    chk("rr_drained", out_empty[1], 1);

    // ---- overflow of input 1 while output 1 is backpressured
    do_reset();
    init_cfg(6, 2);
    for (int q = 0; q < 6; q++) begin
      set_word(0, mkw(1, 0, q)); push[0] = 1'b1;
      tick();
    end
    push = '0;
    ticks(4);
    for (int q = 0; q < 8; q++) begin
      set_word(1, mkw(1, 1, q)); push[1] = 1'b1;
      tick();
    end
    push = '0;
    chk("ovf_full", in_full[1], 1);
    chk("ovf_no_err_yet", error, 0);
    chk("ovf_active", state, 3);
    set_word(1, mkw(1, 1, 8)); push[1] = 1'b1;
    tick();
    push = '0;
    chk("ovf_error", error, 1);
    chk("ovf_state", state, 4);
    set_word(0, mkw(1, 0, 6)); push[0] = 1'b1;
    idx = 1; req = 1'b1;
    tick();
    push = '0; req = 1'b0;
    chk("err_req_ignored", cnt_valid, 0);
    pop[1] = 1'b1;
    for (int q = 0; q < 6; q++) begin
      tick();
      chk($sformatf("err_drain%0d", q), dout(1), mkw(1, 0, q));
    end
    pop[1] = 1'b0;
    ticks(3);
    chk("err_no_xfer", out_empty[1], 1);
    chk("err_sticky", state, 4);
    reset = 1'b0;
    #1;
    chk("err_rst_error", error, 0);
    chk("err_rst_state", state, 0);
    chk("err_rst_full", in_full, 0);
    do_reset();

    // ---- bad thresholds
    init_cfg(3, 5);
    chk("thr_bajo_ge_alto", state, 4);
    chk("thr_err_flag", error, 1);
    do_reset();
    init_cfg(9, 1);
    chk("thr_alto_gt_depth", state, 4);
    do_reset();

    // ---- delivery counter read and wrap on output 2 (alto = DEPTH boundary)
    init_cfg(8, 7);
    chk("thr_boundary_ok", state, 2);
    for (int q = 0; q < 3; q++) send_and_pop(3, 2, q);
    wait_idle();
    idx = 2; req = 1'b1;
    tick();
    req = 1'b0;
    chk("cnt3_valid", cnt_valid, 1);
    chk("cnt3_value", cnt_out, 3);
    tick();
    chk("cnt3_one_cycle", cnt_valid, 0);
    for (int q = 3; q < 33; q++) send_and_pop(q % 4, 2, q);
    wait_idle();
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("cnt_wrap_valid", cnt_valid, 1);
    chk("cnt_wrap_value", cnt_out, 1);

    // ---- randomized traffic against the scoreboard
    do_reset();
    a = $urandom_range(2, DEPTH);
    b = $urandom_range(0, a - 1);
    init_cfg(a, b);
    chk("rnd_cfg_idle", state, 2);
    for (int j = 0; j < NCH; j++) popm[j] = 0;
    for (int k = 0; k < NCH*NCH; k++) seqc[k] = 0;
    mon_en = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!in_full[i] && $urandom_range(0, 2) == 0) begin
          int d;
          logic [DW-1:0] w;
          d = $urandom_range(0, NCH-1);
          w = mkw(d, i, seqc[i*NCH+d]);
          seqc[i*NCH+d]++;
          exp_q[i*NCH+d].push_back(w);
          set_word(i, w);
          push[i] = 1'b1;
        end else begin
          push[i] = 1'b0;
        end
      end
      pop = NCH'($urandom);
      tick();
    end
    push = '0;
    pop = '1;
    n = 0;
    while (!(&out_empty && idle) && n < 400) begin tick(); n++; end
    chk("rnd_drain", {&out_empty, idle}, 2'b11);
    pop = '0;
    ticks(2);
    mon_en = 1'b0;
    rem = 0;
    for (int k = 0; k < NCH*NCH; k++) rem += exp_q[k].size();
    chk("rnd_sb_empty", rem, 0);
    chk("rnd_no_error", error, 0);
    for (int j = 0; j < NCH; j++) begin
      idx = CW'(j); req = 1'b1;
      tick();
      req = 1'b0;
      chk($sformatf("rnd_cntv%0d", j), cnt_valid, 1);
      chk($sformatf("rnd_cnt%0d", j), cnt_out, popm[j] % (1 << CNTW));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
